// File: rtl/conv33_window_gen.sv
// conv33_window_gen: turns a raster-order pixel stream into valid-padding 3x3 windows.
// Two line buffers hold the previous two rows; a 3x3 shift window collects the
// current neighbourhood, and a registered output stage presents one window at a
// time behind a valid/ready handshake with start/done frame framing.
module conv33_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic                  pix_valid_in,
  output logic                  pix_ready_out,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  win_valid_out,
  input  logic                  win_ready_in,
  output logic [DATA_WIDTH-1:0] win_0_0,
  output logic [DATA_WIDTH-1:0] win_0_1,
  output logic [DATA_WIDTH-1:0] win_0_2,
  output logic [DATA_WIDTH-1:0] win_1_0,
  output logic [DATA_WIDTH-1:0] win_1_1,
  output logic [DATA_WIDTH-1:0] win_1_2,
  output logic [DATA_WIDTH-1:0] win_2_0,
  output logic [DATA_WIDTH-1:0] win_2_1,
  output logic [DATA_WIDTH-1:0] win_2_2
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_pix_taken;
  logic          frame_start;
  logic          accept;
  logic          emit;

  // lb0 holds row r-2, lb1 holds row r-1 at the column being written
  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];

  // Shift window indexed [row][col]; col 2 is the newest column
  logic [DATA_WIDTH-1:0] sw_p0  [3][3];
  logic [DATA_WIDTH-1:0] sw_nxt [3][3];
  logic [DATA_WIDTH-1:0] new_col [3];

  logic [DATA_WIDTH-1:0] win_p1 [3][3];
  logic                  vld_p1;

  assign frame_start = (state == S_IDLE) && start;
  assign accept      = pix_valid_in && pix_ready_out;
  assign emit        = accept && (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);

  // Frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Frame sequencing, input back-pressure and the done pulse
  always_comb begin
    state_nxt     = state;
    done          = 1'b0;
    pix_ready_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        // A held output window blocks new pixels so nothing is overwritten
        pix_ready_out = !last_pix_taken && (!vld_p1 || win_ready_in);
        if (last_pix_taken && vld_p1 && win_ready_in) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster position of the next pixel and end-of-frame marker
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col            <= '0;
      row            <= '0;
      last_pix_taken <= 1'b0;
    end else if (frame_start) begin
      col            <= '0;
      row            <= '0;
      last_pix_taken <= 1'b0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if ((row == ROW_LAST) && (col == COL_LAST)) last_pix_taken <= 1'b1;
    end
  end

  // Next shift window: shift left, clear stale columns at row start, insert new column
  always_comb begin
    new_col[0] = lb0[col];
    new_col[1] = lb1[col];
    new_col[2] = pix_data;
    for (int i = 0; i < 3; i++) begin
      sw_nxt[i][0] = (col == '0) ? '0 : sw_p0[i][1];
      sw_nxt[i][1] = (col == '0) ? '0 : sw_p0[i][2];
      sw_nxt[i][2] = new_col[i];
    end
  end

  // Stage p0: line buffers and shift window advance on each accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= pix_data;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          sw_p0[i][j] <= sw_nxt[i][j];
        end
      end
    end
  end

  // Stage p1: output valid, held until handshake, re-armed by a new emit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
    end else if (frame_start) begin
      vld_p1 <= 1'b0;
    end else if (emit) begin
      vld_p1 <= 1'b1;
    end else if (win_ready_in) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage p1: output window registers, loaded only when a complete window is emitted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_p1[i][j] <= '0;
        end
      end
    end else if (emit) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_p1[i][j] <= sw_nxt[i][j];
        end
      end
    end
  end

  assign win_valid_out = vld_p1;
  assign win_0_0 = win_p1[0][0];
  assign win_0_1 = win_p1[0][1];
  assign win_0_2 = win_p1[0][2];
  assign win_1_0 = win_p1[1][0];
  assign win_1_1 = win_p1[1][1];
  assign win_1_2 = win_p1[1][2];
  assign win_2_0 = win_p1[2][0];
  assign win_2_1 = win_p1[2][1];
  assign win_2_2 = win_p1[2][2];

endmodule

// File: tb/tb_conv33_window_gen.sv
// Testbench for conv33_window_gen: a 4x4 and a 5x4 instance share one stimulus
// path; expected windows come from slicing a stored image in plain arithmetic.
module tb_conv33_window_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       win_ready;
  logic       sel;
  logic       start4, start5;

  logic       done4, prdy4, wv4;
  logic       done5, prdy5, wv5;
  logic [7:0] w4 [9];
  logic [7:0] w5 [9];

  logic        done_o, prdy_o, wv_o;
  logic [71:0] obs_win;

  int tests = 0;
  int fails = 0;

  logic [7:0] img [32];

  always #5 clk = ~clk;

  assign start4 = start && !sel;
  assign start5 = start && sel;
  assign done_o = sel ? done5 : done4;
  assign prdy_o = sel ? prdy5 : prdy4;
  assign wv_o   = sel ? wv5   : wv4;

  always_comb begin
    obs_win = '0;
    for (int i = 0; i < 9; i++) obs_win[8*(8-i) +: 8] = sel ? w5[i] : w4[i];
  end

  conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .done(done4),
    .pix_valid_in(pix_valid), .pix_ready_out(prdy4), .pix_data(pix_data),
    .win_valid_out(wv4), .win_ready_in(win_ready),
    .win_0_0(w4[0]), .win_0_1(w4[1]), .win_0_2(w4[2]),
    .win_1_0(w4[3]), .win_1_1(w4[4]), .win_1_2(w4[5]),
    .win_2_0(w4[6]), .win_2_1(w4[7]), .win_2_2(w4[8])
  );

  conv33_window_gen #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(4)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .done(done5),
    .pix_valid_in(pix_valid), .pix_ready_out(prdy5), .pix_data(pix_data),
    .win_valid_out(wv5), .win_ready_in(win_ready),
    .win_0_0(w5[0]), .win_0_1(w5[1]), .win_0_2(w5[2]),
    .win_1_0(w5[3]), .win_1_1(w5[4]), .win_1_2(w5[5]),
    .win_2_0(w5[6]), .win_2_1(w5[7]), .win_2_2(w5[8])
  );

  task automatic chk(input string tag, input logic [71:0] o, input logic [71:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Window centred so that (r,c) is its bottom-right pixel, top-left packed first
  function automatic logic [71:0] model_win(input int W, input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(8-(3*i+j)) +: 8] = img[(r-2+i)*W + (c-2+j)];
    return w;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, 72'(wv_o), 72'(0));
    chk({tag, "_done"},  72'(done_o), 72'(0));
    chk({tag, "_pix_ready"}, 72'(prdy_o), 72'(0));
    chk({tag, "_window"}, obs_win, 72'(0));
  endtask

  // rdy_mode: 0 always ready, 1 stall window #2 for 5 clk, 2 random ready
  task automatic run_frame(input bit s, input int W, input int H, input int gap_pct,
                           input int rdy_mode, input int mid_start, input int abort_at,
                           output logic [71:0] first_w, output logic [71:0] last_w);
    int N, pi, hs, stallcnt, r, c;
    bit vexp, done_exp, got_done, acc, hs_now, emit, held_chk, aborted;
    logic [71:0] held, w;
    logic [71:0] expq [$];
    N = W * H; pi = 0; hs = 0; stallcnt = 0;
    vexp = 0; done_exp = 0; got_done = 0; held_chk = 0; aborted = 0;
    held = '0; first_w = '0; last_w = '0;
    for (int rr = 2; rr < H; rr++)
      for (int cc = 2; cc < W; cc++) expq.push_back(model_win(W, rr, cc));
    sel = s;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("win_valid", 72'(wv_o), 72'(vexp));
      chk("done", 72'(done_o), 72'(done_exp));
      if (held_chk) chk("hold_stable", obs_win, held);
      if (done_exp) begin got_done = 1; break; end
      if (abort_at > 0 && pi == abort_at) begin aborted = 1; break; end
      start = (cyc == 0) || (cyc == mid_start);
      if (pi < N) begin
        pix_valid = ($urandom_range(99) >= gap_pct);
        pix_data  = img[pi];
      end else begin
        pix_valid = 1'b1;
        pix_data  = 8'hEE;
      end
      case (rdy_mode)
        1: begin
          if (wv_o && hs == 1 && stallcnt < 5) begin win_ready = 1'b0; stallcnt++; end
          else win_ready = 1'b1;
        end
        2: win_ready = ($urandom_range(99) < 70);
        default: win_ready = 1'b1;
      endcase
      #1;
      if (pi >= N) chk("no_extra_pixel", 72'(prdy_o), 72'(0));
      acc    = pix_valid && prdy_o && (pi < N);
      hs_now = vexp && win_ready;
      held_chk = vexp && !win_ready;
      if (held_chk) begin
        chk("stall_pix_ready", 72'(prdy_o), 72'(0));
        held = obs_win;
      end
      done_exp = 0;
      if (hs_now) begin
        tests++;
        assert (expq.size() != 0) else begin
          fails++;
          $error("FAIL extra_window observed=%0h expected=none", obs_win);
        end
        if (expq.size() != 0) begin
          w = expq.pop_front();
          chk("window", obs_win, w);
          if (hs == 0) first_w = obs_win;
          last_w = obs_win;
          hs++;
          if (expq.size() == 0) done_exp = 1;
        end
      end
      r = pi / W;
      c = pi % W;
      emit = acc && (r >= 2) && (c >= 2);
      if (emit) vexp = 1;
      else if (hs_now) vexp = 0;
      if (acc) pi++;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    if (!aborted) begin
      tests++;
      assert (got_done) else begin
        fails++;
        $error("FAIL frame_timeout observed=no_done expected=done");
      end
      chk("windows_left", 72'(expq.size()), 72'(0));
    end
  endtask

  initial begin
    logic [71:0] fw, lw;
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = '0; win_ready = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1; check_quiet("reset4");
    sel = 1'b1; #1; check_quiet("reset5");
    @(negedge clk);
    rst = 1'b1;

    // 4x4 ramp, always ready
    for (int k = 0; k < 16; k++) img[k] = 8'(k);
    run_frame(0, 4, 4, 0, 0, -1, 0, fw, lw);
    chk("t1_first", fw, 72'h00_01_02_04_05_06_08_09_0A);
    chk("t1_last",  lw, 72'h05_06_07_09_0A_0B_0D_0E_0F);

    // same frame, second window stalled 5 clk
    run_frame(0, 4, 4, 0, 1, -1, 0, fw, lw);

    // 5x4 random pixels with ~50% input gaps
    for (int k = 0; k < 20; k++) img[k] = 8'($urandom);
    run_frame(1, 5, 4, 50, 0, -1, 0, fw, lw);
    run_frame(1, 5, 4, 50, 2, -1, 0, fw, lw);

    // start pulsed mid-frame is ignored
    for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
    run_frame(0, 4, 4, 20, 0, 6, 0, fw, lw);

    // reset after 7 pixels, then a fresh frame 100..115
    for (int k = 0; k < 16; k++) img[k] = 8'(200 + k);
    run_frame(0, 4, 4, 0, 0, -1, 7, fw, lw);
    rst = 1'b0;
    #1; check_quiet("abort");
    repeat (2) @(negedge clk);
    check_quiet("abort_hold");
    rst = 1'b1;
    for (int k = 0; k < 16; k++) img[k] = 8'(100 + k);
    run_frame(0, 4, 4, 0, 0, -1, 0, fw, lw);
    chk("t5_first", fw, 72'h64_65_66_68_69_6A_6C_6D_6E);

    // back-to-back frames, random data and random ready
    for (int k = 0; k < 20; k++) img[k] = 8'($urandom);
    run_frame(1, 5, 4, 30, 2, -1, 0, fw, lw);
    for (int k = 0; k < 20; k++) img[k] = 8'($urandom);
    run_frame(1, 5, 4, 30, 2, -1, 0, fw, lw);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
